// File: rtl/lane_tx_crc_pkg.sv
// Shared CRC-32C constants, diagnostic-word field bounds and the 64-bit XOR networks.
// Networks shift MSB-first (non-reflected), matching the receive-side checker.
package lane_tx_crc_pkg;

   localparam logic [31:0] CRC32C_POLY = 32'h1EDC6F41;
   localparam logic [31:0] CRC32C_INIT = 32'hffffffff;
   localparam int          DIAG_CRC_HI = 31;
   localparam int          DIAG_CRC_LO = 0;

   typedef struct packed {
      logic        diag;
      logic [63:0] data;
   } lane_word_t;

   function automatic logic [31:0] crc32c_shift64(input logic [31:0] c_in, input logic [63:0] d);
      logic [31:0] c;
      logic        fb;
      c = c_in;
      for (int i = 63; i >= 0; i--) begin
         fb = c[31] ^ d[i];
         c  = {c[30:0], 1'b0} ^ (fb ? CRC32C_POLY : 32'h0);
      end
      return c;
   endfunction

   // Linear split: crc(src, d) == dat64_only(d) ^ zer64(src).
   function automatic logic [31:0] crc32c_dat64_only(input logic [63:0] d);
      return crc32c_shift64(32'h0, d);
   endfunction

   function automatic logic [31:0] crc32c_zer64(input logic [31:0] c);
      return crc32c_shift64(c, 64'h0);
   endfunction

endpackage

// File: rtl/lane_tx_crc_step.sv
// One 64-bit CRC-32C update: seed select, data and zero-advance networks, XOR.
// Purely combinational.
module lane_tx_crc_step
   import lane_tx_crc_pkg::*;
#(
   parameter logic [31:0] CRC_INIT = CRC32C_INIT
) (
   input  logic [31:0] crc,
   input  logic        restart,
   input  logic [63:0] data,
   output logic [31:0] crc_next
);

   logic [31:0] src;

   assign src      = restart ? CRC_INIT : crc;
   assign crc_next = crc32c_dat64_only(data) ^ crc32c_zer64(src);

endmodule

// File: rtl/lane_tx_crc.sv
// Interlaken TX lane CRC-32C generator/inserter; LANE_TX_CRC_ERR_INJECT_EN enables inject_err.
// Fixed 3-cycle latency, no backpressure: every input word emerges once, in order, gaps kept.
module lane_tx_crc
   import lane_tx_crc_pkg::*;
#(
   parameter logic [31:0] CRC_INIT = CRC32C_INIT,
   parameter int          LATENCY  = 3
) (
   input  logic        clk,
   input  logic        arst,
   input  logic [63:0] din,
   input  logic        din_valid,
   input  logic        diag_word,
   input  logic        inject_err,
   output logic [63:0] dout,
   output logic        dout_valid,
   output logic        dout_diag
);

   if (LATENCY != 3) begin : g_latency_chk
      $error("lane_tx_crc: LATENCY must be 3");
   end

   lane_word_t  s1_word, s2_word;
   logic [63:0] s1_mask, din_mask, dout_word;
   logic        s1_valid, s2_valid;
   logic [31:0] crc, crc_next, crc_field;
   logic        restart;

   always_comb begin
      din_mask = din;
      if (diag_word) din_mask[DIAG_CRC_HI:DIAG_CRC_LO] = '0;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         s1_valid <= 1'b0;
         s1_word  <= '0;
         s1_mask  <= '0;
      end else begin
         s1_valid <= din_valid;
         if (din_valid) begin
            s1_word <= '{diag: diag_word, data: din};
            s1_mask <= din_mask;
         end
      end
   end

   lane_tx_crc_step #(.CRC_INIT(CRC_INIT)) u_step (
      .crc      (crc),
      .restart  (restart),
      .data     (s1_mask),
      .crc_next (crc_next)
   );

   // restart lets the word right after a diag word seed from CRC_INIT with no bubble.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         s2_valid <= 1'b0;
         s2_word  <= '0;
         crc      <= CRC_INIT;
         restart  <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_word <= s1_word;
            crc     <= crc_next;
            restart <= s1_word.diag;
         end
      end
   end

`ifdef LANE_TX_CRC_ERR_INJECT_EN
   logic s1_inj, s2_inj;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         s1_inj <= 1'b0;
         s2_inj <= 1'b0;
      end else begin
         if (din_valid) s1_inj <= diag_word & inject_err;
         if (s1_valid)  s2_inj <= s1_inj;
      end
   end

   // Only the emitted field is corrupted; the running CRC chain stays clean.
   assign crc_field = ~crc ^ {31'b0, s2_inj};
`else
   logic unused_inject_err;
   assign unused_inject_err = inject_err;
   assign crc_field         = ~crc;
`endif

   always_comb begin
      dout_word = s2_word.data;
      if (s2_word.diag) dout_word[DIAG_CRC_HI:DIAG_CRC_LO] = crc_field;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_diag  <= 1'b0;
      end else begin
         dout_valid <= s2_valid;
         dout_diag  <= s2_valid & s2_word.diag;
         if (s2_valid) dout <= dout_word;
      end
   end

endmodule

// File: tb/tb_lane_tx_crc.sv
// Directed bench for lane_tx_crc: bit-serial CRC-32C model predicts each output word,
// and a loopback receive checker recomputes the CRC from dout itself.
module tb_lane_tx_crc;

   localparam logic [31:0] POLY = 32'h1EDC6F41;
   localparam logic [31:0] INIT = 32'hffffffff;

   logic        clk = 1'b0;
   logic        arst = 1'b1;
   logic [63:0] din = '0;
   logic        din_valid = 1'b0;
   logic        diag_word = 1'b0;
   logic        inject_err = 1'b0;
   logic [63:0] dout;
   logic        dout_valid;
   logic        dout_diag;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic        v;
      logic        diag;
      logic [63:0] data;
      logic        inj;
   } exp_t;

   exp_t        q[$];
   logic [31:0] m_crc;
   logic        m_start;
   logic [63:0] m_dout;
   logic [31:0] rx_crc;
   logic        rx_start;
   int          rx_errs;

   lane_tx_crc dut (
      .clk        (clk),
      .arst       (arst),
      .din        (din),
      .din_valid  (din_valid),
      .diag_word  (diag_word),
      .inject_err (inject_err),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_diag  (dout_diag)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ser(input logic [31:0] c_in, input logic [63:0] d);
      logic [31:0] c;
      c = c_in;
      for (int i = 63; i >= 0; i--)
         c = (c[31] ^ d[i]) ? ({c[30:0], 1'b0} ^ POLY) : {c[30:0], 1'b0};
      return c;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_t e;
      e = '{v: 1'b0, diag: 1'b0, data: 64'h0, inj: 1'b0};
      q.delete();
      q.push_back(e);
      q.push_back(e);
      m_crc    = INIT;
      m_start  = 1'b1;
      m_dout   = 64'h0;
      rx_crc   = INIT;
      rx_start = 1'b1;
   endtask

   task automatic check_out();
      exp_t        e;
      logic [63:0] mk;
      logic        bad;
      e = q.pop_front();
      if (e.v) m_dout = e.data;
      chk("dout_valid", {63'b0, dout_valid}, {63'b0, e.v});
      chk("dout_diag", {63'b0, dout_diag}, {63'b0, e.v & e.diag});
      chk("dout", dout, m_dout);
      // Loopback receiver works only from what the DUT emitted.
      if (dout_valid) begin
         mk = dout;
         if (dout_diag) mk[31:0] = 32'h0;
         rx_crc   = ser(rx_start ? INIT : rx_crc, mk);
         rx_start = dout_diag;
         if (dout_diag) begin
            bad = (dout[31:0] !== ~rx_crc);
            if (bad) rx_errs++;
            chk("rx_crc_error", {63'b0, bad}, {63'b0, e.inj});
         end
      end
   endtask

   task automatic step(input logic v, input logic dg, input logic [63:0] d, input logic inj);
      exp_t        e;
      logic [63:0] mk;
      din        = d;
      din_valid  = v;
      diag_word  = dg;
      inject_err = inj;
      e = '{v: v, diag: dg, data: d, inj: 1'b0};
      if (v) begin
         mk = d;
         if (dg) mk[31:0] = 32'h0;
         m_crc   = ser(m_start ? INIT : m_crc, mk);
         m_start = dg;
         if (dg) begin
`ifdef LANE_TX_CRC_ERR_INJECT_EN
            e.inj = inj;
`endif
            e.data = {d[63:32], ~m_crc ^ {31'b0, e.inj}};
         end
      end
      q.push_back(e);
      @(posedge clk);
      #1;
      check_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, {$urandom, $urandom}, 1'b0);
   endtask

   task automatic do_reset();
      arst      = 1'b1;
      din_valid = 1'b0;
      diag_word = 1'b0;
      #1;
      chk("rst_dout", dout, 64'h0);
      chk("rst_valid", {63'b0, dout_valid}, 64'h0);
      chk("rst_diag", {63'b0, dout_diag}, 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      arst = 1'b0;
      model_reset();
   endtask

   // Frame of words 1..7 then diag, with optional idle gaps (diag_word toggled in gaps).
   task automatic frame17(input bit gaps, input logic [63:0] dg_dat);
      for (int w = 1; w <= 7; w++) begin
         if (gaps && (w % 2 == 1)) step(1'b0, 1'b1, 64'hBAD0_BAD0_BAD0_BAD0, 1'b0);
         if (gaps && w == 4) idle(2);
         step(1'b1, 1'b0, 64'(w), 1'b0);
      end
      if (gaps) idle(1);
      step(1'b1, 1'b1, dg_dat, 1'b0);
   endtask

   initial begin
      rx_errs = 0;
      model_reset();
      #2;
      chk("rst_dout", dout, 64'h0);
      chk("rst_valid", {63'b0, dout_valid}, 64'h0);
      chk("rst_diag", {63'b0, dout_diag}, 64'h0);
      @(posedge clk);
      #1;
      arst = 1'b0;

      // Lone diag word straight after reset, then same word with a different CRC field.
      step(1'b1, 1'b1, 64'hA5A5_0000_DEAD_BEEF, 1'b0);
      idle(4);
      step(1'b1, 1'b1, 64'hA5A5_0000_0000_0000, 1'b0);
      idle(4);

      // Gap-free and gapped versions of the same metaframe.
      frame17(1'b0, 64'hC0DE_0001_1234_5678);
      idle(3);
      frame17(1'b1, 64'hC0DE_0001_8765_4321);
      idle(3);

      // Back-to-back metaframes with no idle between diag and next word.
      for (int w = 0; w < 3; w++) step(1'b1, 1'b0, 64'hF0F0_0000_0000_0000 + 64'(w), 1'b0);
      step(1'b1, 1'b1, 64'h1111_2222_3333_4444, 1'b0);
      frame17(1'b0, 64'hC0DE_0001_1234_5678);
      step(1'b1, 1'b1, 64'h5555_6666_0000_0000, 1'b0);
      idle(3);

      // Reset after word 3 of a metaframe, then a full clean metaframe.
      for (int w = 1; w <= 3; w++) step(1'b1, 1'b0, 64'(w), 1'b0);
      do_reset();
      frame17(1'b0, 64'hC0DE_0001_1234_5678);
      idle(3);

      // Random metaframes looped back through the receive checker.
      for (int f = 0; f < 1000; f++) begin
         int n;
         n = $urandom_range(0, 6);
         for (int w = 0; w < n; w++) begin
            if ($urandom_range(0, 3) == 0) step(1'b0, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0);
            step(1'b1, 1'b0, {$urandom, $urandom}, 1'b0);
         end
         step(1'b1, 1'b1, {$urandom, $urandom}, 1'b0);
      end
      idle(3);
      chk("rx_err_total", 64'(rx_errs), 64'h0);

`ifdef LANE_TX_CRC_ERR_INJECT_EN
      rx_errs = 0;
      for (int f = 1; f <= 10; f++) begin
         for (int w = 0; w < 4; w++) step(1'b1, 1'b0, {$urandom, $urandom}, 1'b1);
         step(1'b1, 1'b1, {$urandom, $urandom}, (f == 5));
      end
      idle(3);
      chk("inject_err_pulses", 64'(rx_errs), 64'h1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/lane_tx_crc.md
Name: lane_tx_crc

Overview:
- Transmit-side Interlaken lane CRC-32C generator/inserter.
- Accumulates CRC-32C over every 64-bit word of a metaframe, ending with the diagnostic word. The diagnostic word's CRC field [31:0] is treated as zero during accumulation.
- Overwrites diagnostic word [31:0] with the inverted CRC.
- Sits between the lane framer (upstream, marks diagnostic word) and the scrambler/gearbox (downstream), at fixed 3-cycle latency.

Parameters:
- CRC_INIT, 32'hffffffff, CRC seed loaded at reset and at each metaframe start.
- LATENCY, 3, fixed din-to-dout latency. Informational only; RTL asserts LATENCY==3.

Ports:
- clk  in  1  lane clock
- arst  in  1  reset; asynchronous, active-high
- din  in  64  lane word from framer
- din_valid  in  1  din carries a word this cycle; may have arbitrary gaps, back-to-back allowed
- diag_word  in  1  qualifies din as the metaframe diagnostic word; ignored when din_valid=0
- inject_err  in  1  CRC corruption request; only used with LANE_TX_CRC_ERR_INJECT_EN
- dout  out  64  lane word with CRC inserted
- dout_valid  out  1  dout carries a word
- dout_diag  out  1  dout is a diagnostic word

Behaviour:
- Reset (arst=1): dout=0, dout_valid=0, dout_diag=0, all stage registers 0, crc=CRC_INIT, restart=0. Reset mid-metaframe discards the partial CRC; the next metaframe starts from CRC_INIT.
- Stage 1 (edge after sample t), when din_valid:
  - s1_data <= din; s1_diag <= diag_word.
  - s1_mask <= diag_word ? {din[63:32],32'h0} : din.
  - s1_valid <= din_valid. s1_data, s1_diag and s1_mask hold when invalid.
- Stage 2 (t+2 edge), when s1_valid:
  - crc <= dat64(s1_mask) ^ zer64(src).
  - src = restart ? CRC_INIT : crc.
  - dat64 and zer64 are the existing CRC-32C 64-bit data-only and zero-advance XOR networks, poly 0x1EDC6F41, same bit order as the receive checker.
  - restart <= s1_diag; cleared by the next valid update.
  - s2_data/s2_diag/s2_valid pipeline forward. When s1_valid=0, crc and restart hold.
- Stage 3 (t+3 edge):
  - dout_valid <= s2_valid; dout_diag <= s2_valid & s2_diag.
  - dout <= s2_diag ? {s2_data[63:32], ~crc} : s2_data.
  - dout updates only when s2_valid.
- Latency: exactly 3 cycles, independent of gaps. No backpressure; no words dropped, reordered or added.
- Diag word din[31:0] is don't-care. It never affects the CRC or dout.
- Back-to-back metaframes: a diagnostic word immediately followed by a valid word must seed that next word from CRC_INIT in the same cycle via restart. No bubble is required.
- Diagnostic word with no preceding words (first valid after reset): CRC covers the masked diag word only, seeded from CRC_INIT.
- diag_word=1 with din_valid=0: no effect.

Optional Feature:
- LANE_TX_CRC_ERR_INJECT_EN defined:
  - inject_err sampled with din_valid & diag_word; that word's inserted field becomes ~crc ^ 32'h1.
  - The internal CRC chain is unaffected; only one metaframe is corrupted per request.
- Undefined: inject_err ignored, no logic generated; the port remains for a stable interface.

Decomposition:
- Shared package/include: CRC32C_POLY=32'h1EDC6F41, CRC32C_INIT=32'hffffffff, diag CRC field bounds (DIAG_CRC_HI=31, DIAG_CRC_LO=0).
- Reuse the existing crc32c_dat64_only and crc32c_zer64 XOR networks.
- One natural sub-module, lane_tx_crc_step: src select + both networks + XOR. Combinational; reused by the bench model.

Test Plan:
- Reset then single valid diag word din=64'hA5A5_0000_DEAD_BEEF -> 3 cycles later dout_valid=1, dout_diag=1, dout[63:32]=32'hA5A50000, dout[31:0]=~CRC32C(CRC_INIT, 64'hA5A5_0000_0000_0000) per golden model; CRC field 32'hDEADBEEF has no effect.
- Metaframe of 7 words 64'h1..64'h7 plus diag, din_valid with random gaps -> output order and gaps preserved with latency 3; non-diag words bit-exact; inserted CRC matches golden model and equals the gap-free run's CRC.
- Two back-to-back metaframes, no idle between diag and next word -> second CRC equals that of the same metaframe sent alone after reset.
- Loopback into the receive CRC checker for 1000 random metaframes -> crc_error never asserts.
- arst pulsed mid-metaframe (after word 3) -> outputs 0 within reset; next full metaframe CRC correct.
- With LANE_TX_CRC_ERR_INJECT_EN, inject_err on metaframe 5 of 10 -> only metaframe 5 has CRC bit 0 flipped; receive checker flags exactly one crc_error pulse.
